// File: rtl/floo_pkg.sv
// Shared types and helpers for the source-routed NoC router slice.
//
// Contents:
//   route_consume_state_e : wormhole state of a router input port
//   floo_route_t          : default source-route type (32 bits)
//   floo_hdr_t            : default flit header (route + last marker)
//   floo_flit_t           : default flit (header + 32-bit payload)
//   floo_route_shift      : drops the hop bits already consumed from a route
package floo_pkg;

  typedef enum logic [1:0] {
    HEAD,
    BODY,
    DROP
  } route_consume_state_e;

  localparam int unsigned MaxRouteWidth = 64;

  typedef logic [31:0] floo_route_t;

  typedef struct packed {
    floo_route_t route;
    logic        last;
  } floo_hdr_t;

  typedef struct packed {
    floo_hdr_t   hdr;
    logic [31:0] payload;
  } floo_flit_t;

  // Routes of any width up to MaxRouteWidth are widened to 64 bits by the
  // caller and truncated back afterwards; the logical shift zero-fills the MSBs.
  function automatic logic [MaxRouteWidth-1:0] floo_route_shift(
    input logic [MaxRouteWidth-1:0] route,
    input int unsigned              port_bits
  );
    return route >> port_bits;
  endfunction

endpackage

// File: rtl/floo_route_consume_reg.sv
// One-entry output register holding a flit and its one-hot port select,
// with a valid/ready handshake on both sides.
//
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   valid_i / ready_o  : upstream handshake (ready_o = empty or draining)
//   data_i, sel_i      : flit and port select to store
//   valid_o / ready_i  : downstream handshake
//   data_o, sel_o      : stored flit and port select
module floo_route_consume_reg #(
  parameter type         data_t     = logic,
  parameter int unsigned NumOutputs = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  data_t                 data_i,
  input  logic [NumOutputs-1:0] sel_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output data_t                 data_o,
  output logic [NumOutputs-1:0] sel_o
);

  logic                  valid_q;
  data_t                 data_q;
  logic [NumOutputs-1:0] sel_q;

  // Accepting while the current entry leaves gives full throughput.
  assign ready_o = !valid_q || ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else if (valid_i && ready_o) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      sel_q   <= sel_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;

endmodule

// File: rtl/floo_route_consume.sv
// Router input-port stage that consumes the source route carried in each
// flit header: the lowest PortBits of the route select the output port, the
// route is shifted for the next hop, and the port is held for the rest of
// the packet. Packets whose head names a non-existent port are discarded
// and counted.
//
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   valid_i/ready_o     : input flit handshake
//   flit_i              : input flit
//   valid_o/ready_i     : output flit handshake (towards selected arbiter)
//   flit_o              : registered flit with shifted route
//   sel_o               : one-hot output port, meaningful when valid_o
//   drop_o              : one-cycle pulse per dropped packet
//   drop_cnt_o          : saturating dropped-packet count
module floo_route_consume
  import floo_pkg::*;
#(
  parameter int unsigned NumOutputs = 5,
  parameter type         route_t    = floo_route_t,
  parameter type         flit_t     = floo_flit_t,
  parameter int unsigned CntWidth   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  flit_t                 flit_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output flit_t                 flit_o,
  output logic [NumOutputs-1:0] sel_o,
  output logic                  drop_o,
  output logic [CntWidth-1:0]   drop_cnt_o
);

  localparam int unsigned PortBits   = $clog2(NumOutputs);
  localparam int unsigned RouteWidth = $bits(route_t);

  if (RouteWidth < PortBits) begin : gen_route_width_check
    $error("floo_route_consume: route narrower than PortBits");
  end

  route_consume_state_e  state_q, state_d;
  logic [PortBits-1:0]   port_q, port_d;
  logic [PortBits-1:0]   port;
  logic [PortBits-1:0]   sel_port;
  logic                  port_legal;
  logic                  in_hs;
  logic                  reg_valid;
  logic                  reg_ready;
  logic                  drop;
  logic                  drop_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [NumOutputs-1:0] sel;
  flit_t                 flit_shifted;

  assign port       = flit_i.hdr.route[PortBits-1:0];
  assign port_legal = 32'(port) < NumOutputs;

  // DROP swallows flits without touching the output register.
  assign ready_o = (state_q == DROP) || reg_ready;
  assign in_hs   = valid_i && ready_o;

  always_comb begin
    flit_shifted           = flit_i;
    flit_shifted.hdr.route = route_t'(floo_route_shift(MaxRouteWidth'(flit_i.hdr.route), PortBits));
  end

  assign sel = NumOutputs'(1) << sel_port;

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    sel_port  = port_q;
    reg_valid = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      HEAD: begin
        if (in_hs) begin
          if (port_legal) begin
            reg_valid = 1'b1;
            sel_port  = port;
            port_d    = port;
            if (!flit_i.hdr.last) state_d = BODY;
          end else begin
            drop = 1'b1;
            if (!flit_i.hdr.last) state_d = DROP;
          end
        end
      end
      BODY: begin
        if (in_hs) begin
          reg_valid = 1'b1;
          if (flit_i.hdr.last) state_d = HEAD;
        end
      end
      DROP: begin
        if (in_hs && flit_i.hdr.last) state_d = HEAD;
      end
      default: state_d = HEAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HEAD;
      port_q  <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      drop_q  <= drop;
      if (drop && (cnt_q != '1)) cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  assign drop_o     = drop_q;
  assign drop_cnt_o = cnt_q;

  floo_route_consume_reg #(
    .data_t     (flit_t),
    .NumOutputs (NumOutputs)
  ) i_out_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (reg_valid),
    .ready_o (reg_ready),
    .data_i  (flit_shifted),
    .sel_i   (sel),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (flit_o),
    .sel_o   (sel_o)
  );

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o) |=> (valid_i && $stable(flit_i)))
    else $error("floo_route_consume: input changed while stalled");

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_o |-> $onehot(sel_o))
    else $error("floo_route_consume: sel_o not one-hot");
`endif

endmodule

// File: doc/floo_route_consume.md
Name: floo_route_consume

Overview:
- Router-side counterpart of source-route generation.
- Consumes the pre-computed source route carried in each flit header and selects the output port from the lowest route bits.
- Shifts the route so the next hop sees its own port in the lowest bits.
- Locks the selected port for the whole packet (wormhole) and registers the flit in a one-entry output stage. Sits at each router input port, ahead of the output arbiters.

Parameters:
- NumOutputs, 5, number of router output ports; must be ≥ 2.
- PortBits, $clog2(NumOutputs), route bits consumed per hop (derived; do not override).
- route_t, logic, source route type; width RouteWidth = $bits(route_t), must be ≥ PortBits.
- flit_t, logic, flit type; must contain fields hdr.route (route_t) and hdr.last (1 bit).
- CntWidth, 8, width of the saturating drop counter.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- valid_i  input  1  input flit valid
- ready_o  output  1  input flit ready
- flit_i  input  flit_t  input flit
- valid_o  output  1  output flit valid
- ready_i  input  1  output flit ready (selected port's arbiter)
- flit_o  output  flit_t  registered flit, hdr.route already shifted
- sel_o  output  NumOutputs  one-hot output port, valid when valid_o
- drop_o  output  1  one-cycle pulse when a packet header with an illegal port is dropped
- drop_cnt_o  output  CntWidth  saturating count of dropped packets

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous, active-low. Reset values: valid_o=0, flit_o='0, sel_o='0, drop_o=0, drop_cnt_o=0, FSM=HEAD, locked port=0.
- Handshake: transfer on valid && ready. valid_o does not drop until a handshake. flit_o and sel_o are stable while valid_o=1 and ready_i=0.
- ready_o = (state==DROP) || !valid_o || ready_i; full throughput, combinational path ready_i→ready_o only.
- Latency: exactly 1 cycle from input handshake to valid_o.
- Port extraction: p = flit_i.hdr.route[PortBits-1:0].
- Route shift: flit_o.hdr.route = flit_i.hdr.route >> PortBits, zero-filled at the MSBs. Applied to every flit, head and body. All other flit fields are passed unchanged.
- FSM states: HEAD, BODY, DROP.
- HEAD, on input handshake:
  - If p < NumOutputs: register the flit, set sel_o = 1<<p, and latch p as the locked port. Go to BODY if hdr.last=0, otherwise stay in HEAD.
  - If p ≥ NumOutputs: do not register the flit, leave valid_o unchanged, pulse drop_o, and increment drop_cnt_o, saturating at all-ones. Go to DROP if hdr.last=0, otherwise stay in HEAD.
- BODY, on input handshake: register the flit with sel_o = 1<<locked port; the body flit's p is ignored. On hdr.last=1 go to HEAD.
- DROP: ready_o=1. Every input flit is consumed and discarded with no output. On a handshake with hdr.last=1 go to HEAD.
- Simultaneous events: an output handshake and a new input handshake in the same cycle load the new flit into the register, so valid_o stays 1.
- Single-flit packet: head with last=1 is handled entirely in HEAD.
- Reset mid-packet: returns to HEAD and clears the output register. Upstream is responsible for flushing.
- Assertions:
  - valid_i and flit_i stable while ready_o=0.
  - sel_o is one-hot when valid_o=1.
  - RouteWidth ≥ PortBits, checked at elaboration.

Decomposition:
- floo_pkg:
  - the route_consume_state_e enum (HEAD, BODY, DROP);
  - a function floo_route_shift(route, PortBits) shared with route-generation code.
- Output register: a dedicated sub-module floo_route_consume_reg (one-entry flit+sel register with valid/ready), reusable for other router stages.
- FSM, extraction and drop counter stay in the top module.

Test Plan:
- NumOutputs=5, PortBits=3. Single-flit packet route=0x0000_00D2, last=1, ready_i=1 → next cycle valid_o=1, sel_o=5'b00100, flit_o.hdr.route=0x0000_001A. FSM stays HEAD.
- 4-flit packet with head route port 3. Body flits carry route bits 0 and 1 → all four outputs have sel_o=5'b01000. FSM returns to HEAD after the last flit.
- Head with port 6 and last=0, followed by 2 body flits → drop_o pulses once on the head, drop_cnt_o goes 0→1, ready_o=1 throughout, no valid_o. The next legal head is routed normally.
- ready_i held 0 for 5 cycles with a flit in the register → valid_o, flit_o and sel_o are stable, ready_o=0. On ready_i=1 the pending flit transfers and a new one loads in the same cycle, so valid_o stays 1.
- CntWidth=2, 5 illegal single-flit heads → drop_cnt_o reads 1, 2, 3, 3, 3.
- Assert rst_ni while in BODY with valid_o=1 → valid_o=0 and drop_cnt_o=0 asynchronously. The first flit after reset is treated as a head.
